// File: rtl/carwash_pkg.sv
// Shared definitions for the car-wash bay: FSM state codes, wash selection codes
// and the default wash watchdog limit.
package carwash_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArb   = 3'd1,
        StStart = 3'd2,
        StWash  = 3'd3,
        StDone  = 3'd4,
        StFault = 3'd5
    } state_e;

    localparam logic [1:0] SelInvalid   = 2'd0;
    localparam logic [1:0] SelBasic     = 2'd1;
    localparam logic [1:0] SelBasicPlus = 2'd2;
    localparam logic [1:0] SelDetail    = 2'd3;

    localparam int unsigned WashTimeoutDefault = 200;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, and a tie goes to the
// lane that was not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_served ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/bay_scheduler.sv
// Wash-bay scheduler: arbitrates two paid lanes, sequences the wash datapath and
// watches each wash with a timeout that parks the bay in a fault state.
module bay_scheduler
    import carwash_pkg::*;
#(
    parameter int unsigned WASH_TIMEOUT = WashTimeoutDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] approved,
    input  logic [1:0] sel0,
    input  logic [1:0] sel1,
    input  logic       wash_complete,
    input  logic       clear_fault,
    output logic [1:0] grant,
    output logic [1:0] wash_sel,
    output logic       wash_reset,
    output logic       wash_start,
    output logic       busy,
    output logic       fault,
    output logic [7:0] served_count,
    output logic [2:0] state
);

    localparam logic [7:0] TimeoutVal = 8'(WASH_TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] wash_sel_q, wash_sel_d;
    logic [7:0] watchdog_q, watchdog_d;
    logic [7:0] served_q, served_d;
    logic       last_q, last_d;
    logic       winner_q, winner_d;

    logic [1:0] qual;
    logic [1:0] arb_gnt;
    logic [7:0] wd_inc;

    assign qual[0] = req[0] & approved[0] & (sel0 != SelInvalid);
    assign qual[1] = req[1] & approved[1] & (sel1 != SelInvalid);
    assign wd_inc  = watchdog_q + 8'd1;

    rr_arbiter2 u_arb (
        .req         (qual),
        .last_served (last_q),
        .gnt         (arb_gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wash_sel_q <= 2'd0;
            watchdog_q <= 8'd0;
            served_q   <= 8'd0;
            last_q     <= 1'b1;
            winner_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wash_sel_q <= wash_sel_d;
            watchdog_q <= watchdog_d;
            served_q   <= served_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wash_sel_d = wash_sel_q;
        watchdog_d = watchdog_q;
        served_d   = served_q;
        last_d     = last_q;
        winner_d   = winner_q;
        grant      = 2'b00;
        wash_reset = 1'b1;
        wash_start = 1'b0;
        busy       = 1'b0;
        fault      = 1'b0;

        case (state_q)
            StIdle: begin
                if (|qual) state_d = StArb;
            end
            StArb: begin
                // Qualification is re-evaluated here; a lane that dropped out since IDLE
                // sends the bay back without a grant.
                if (|arb_gnt) begin
                    grant      = arb_gnt;
                    winner_d   = arb_gnt[1];
                    wash_sel_d = arb_gnt[1] ? sel1 : sel0;
                    state_d    = StStart;
                end else begin
                    state_d = StIdle;
                end
            end
            StStart: begin
                wash_reset = 1'b0;
                wash_start = 1'b1;
                busy       = 1'b1;
                watchdog_d = 8'd0;
                state_d    = StWash;
            end
            StWash: begin
                wash_reset = 1'b0;
                busy       = 1'b1;
                watchdog_d = wd_inc;
                // Completion takes priority over a timeout landing on the same cycle.
                if (wash_complete) begin
                    state_d = StDone;
                end else if (wd_inc == TimeoutVal) begin
                    state_d = StFault;
                end
            end
            StDone: begin
                served_d = (served_q == 8'hFF) ? served_q : served_q + 8'd1;
                last_d   = winner_q;
                state_d  = StIdle;
            end
            StFault: begin
                fault = 1'b1;
                if (clear_fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The selection is visible in the ARB cycle itself, then held from the register.
    assign wash_sel     = (state_q == StArb) ? wash_sel_d : wash_sel_q;
    assign served_count = served_q;
    assign state        = state_q;

endmodule
